// File: rtl/smp_mem_responder.sv
// ---------------------------------------------------------------------------
// smp_mem_responder
//
// Memory-side target of the simple microprocessor bus four-phase req/ack
// handshake. It holds a byte-wide synchronous RAM and inserts WAIT_STATES
// wait cycles before acknowledging. Accesses whose address lies above the
// implemented range are flagged with err. It also keeps a wrapping count of
// completed accesses for debug display.
//
// Ports:
//   clock        in   system clock, all state changes on the rising edge
//   reset        in   synchronous active-high reset (memory is not cleared)
//   req          in   request from initiator, held high until ack is seen
//   we           in   1 = write, 0 = read, sampled with req
//   addr         in   byte address, sampled with req
//   wdata        in   write data, sampled with req
//   rdata        out  read data (write data echoed on writes), valid with ack
//   ack          out  access complete, held until req is sampled low
//   err          out  address out of range, valid with ack
//   busy         out  FSM not idle
//   access_count out  completed accesses, wraps from all-ones to zero
// ---------------------------------------------------------------------------
module smp_mem_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_AW      = 8,
    parameter int WAIT_STATES = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic                   ack,
    output logic                   err,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] access_count
);

    localparam int DEPTH = 2 ** MEM_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Holds WAIT_STATES+1 (up to 16) so the access lands on edge
    // N+1+WAIT_STATES after the request is accepted on edge N.
    logic [4:0]            wait_cnt;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic                  do_access;
    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_idx;

    // Upper address bits only participate in the range check.
    assign in_range = ~|(lat_addr >> MEM_AW);
    assign mem_idx  = lat_addr[MEM_AW-1:0];
    assign busy     = (state != IDLE);

    // A reset arriving on the access edge discards the pending write.
    assign mem_we   = do_access && lat_we && in_range && !reset;

    // Next-state decode
    always_comb begin
        state_nxt = state;
        do_access = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 5'd1) begin
                    do_access = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            ack          <= 1'b0;
            err          <= 1'b0;
            rdata        <= '0;
            access_count <= '0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && req) begin
                wait_cnt <= 5'(WAIT_STATES + 1);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 5'd1;
            end

            if (do_access) begin
                ack          <= 1'b1;
                err          <= !in_range;
                access_count <= access_count + COUNT_WIDTH'(1);
                if (!in_range) begin
                    rdata <= '0;
                end else if (lat_we) begin
                    rdata <= lat_wdata;
                end else begin
                    rdata <= mem[mem_idx];
                end
            end else if (state == ACK && !req) begin
                // rdata intentionally keeps its last value
                ack <= 1'b0;
                err <= 1'b0;
            end
        end
    end

    // Request capture: the access always uses these, so inputs may change
    // (or req may drop) freely once the request has been accepted.
    always_ff @(posedge clock) begin
        if (state == IDLE && req) begin
            lat_addr  <= addr;
            lat_we    <= we;
            lat_wdata <= wdata;
        end
    end

    // RAM write port, no reset so contents survive reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_smp_mem_responder.sv
module tb_smp_mem_responder;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          err;
    logic          busy;
    logic [CW-1:0] access_count;

    int            checks   = 0;
    int            failures = 0;
    logic [CW-1:0] exp_cnt;

    always #5 clock = ~clock;

    smp_mem_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_AW     (8),
        .WAIT_STATES(2),
        .COUNT_WIDTH(CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .ack         (ack),
        .err         (err),
        .busy        (busy),
        .access_count(access_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full handshake with req held until ack; ack must rise 3 edges after accept.
    task automatic bus_access(input string tag, input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                              input logic exp_err);
        we = w; addr = a; wdata = d; req = 1'b1;
        tick();                                   // edge 0: accepted
        chk({tag, "_busy_accept"}, busy, 1'b1);
        chk({tag, "_ack_e0"}, ack, 1'b0);
        // latched values must be used, not the live bus
        addr = ~a; wdata = ~d; we = ~w;
        tick();                                   // edge 1
        tick();                                   // edge 2
        chk({tag, "_ack_e2"}, ack, 1'b0);
        tick();                                   // edge 3
        exp_cnt = exp_cnt + 1'b1;
        chk({tag, "_ack_e3"}, ack, 1'b1);
        chk({tag, "_rdata"}, rdata, exp_rd);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_count"}, access_count, exp_cnt);
        req = 1'b0;
        tick();                                   // req seen low
        chk({tag, "_ack_fall"}, ack, 1'b0);
        chk({tag, "_err_fall"}, err, 1'b0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
        chk({tag, "_rdata_hold"}, rdata, exp_rd);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        exp_cnt = '0;

        // 1. Reset with random bus activity
        for (int i = 0; i < 2; i++) begin
            req   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            addr  = 16'($urandom);
            wdata = 8'($urandom);
            tick();
            chk("rst_ack", ack, 1'b0);
            chk("rst_err", err, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_rdata", rdata, 8'h00);
            chk("rst_count", access_count, 4'h0);
        end
        reset = 1'b0; req = 1'b0;
        tick();
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_ack", ack, 1'b0);

        // 2. Write then read back
        bus_access("wr12", 1'b1, 16'h0012, 8'hA5, 8'hA5, 1'b0);
        bus_access("rd12", 1'b0, 16'h0012, 8'h00, 8'hA5, 1'b0);
        chk("count_after_2", access_count, 4'h2);

        // 3. Out-of-range write must not alias onto address 0
        bus_access("wr00", 1'b1, 16'h0000, 8'h11, 8'h11, 1'b0);
        bus_access("wr03", 1'b1, 16'h0003, 8'h33, 8'h33, 1'b0);
        bus_access("oor_wr", 1'b1, 16'h0100, 8'h5A, 8'h00, 1'b1);
        bus_access("oor_rd", 1'b0, 16'h8042, 8'h00, 8'h00, 1'b1);
        bus_access("rd00", 1'b0, 16'h0000, 8'h00, 8'h11, 1'b0);

        // 4. Back-to-back writes (busy low exactly one cycle between them)
        for (int i = 0; i < 4; i++) begin
            bus_access($sformatf("b2b%0d", i), 1'b1, 16'(16'h0020 + i),
                       8'(8'hC0 + i), 8'(8'hC0 + i), 1'b0);
        end
        bus_access("rd21", 1'b0, 16'h0021, 8'h00, 8'hC1, 1'b0);

        // 5. Reset mid-WAIT discards the pending write
        we = 1'b1; addr = 16'h0003; wdata = 8'h07; req = 1'b1;
        tick();
        chk("midw_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0; req = 1'b0;
        exp_cnt = '0;
        chk("midw_ack", ack, 1'b0);
        chk("midw_busy_rst", busy, 1'b0);
        chk("midw_count", access_count, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midw_no_ack", ack, 1'b0);
            chk("midw_idle", busy, 1'b0);
        end
        bus_access("rd03", 1'b0, 16'h0003, 8'h00, 8'h33, 1'b0);

        // 6a. Early req drop: single-cycle ack pulse
        we = 1'b0; addr = 16'h0020; req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        chk("early_ack_e2", ack, 1'b0);
        chk("early_busy", busy, 1'b1);
        tick();
        exp_cnt = exp_cnt + 1'b1;
        chk("early_ack_e3", ack, 1'b1);
        chk("early_rdata", rdata, 8'hC0);
        chk("early_count", access_count, exp_cnt);
        tick();
        chk("early_ack_pulse", ack, 1'b0);
        chk("early_idle", busy, 1'b0);

        // 6b. 16 more accesses force access_count through 0xF -> 0x0
        for (int i = 0; i < 16; i++) begin
            bus_access($sformatf("wrap%0d", i), 1'b0, 16'h0012, 8'h00, 8'hA5, 1'b0);
        end
        chk("wrap_final", access_count, 4'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
